// File: rtl/pattern_decoder_ctrl.sv
// Sequencing controller for the serial pattern decoder: clears it, streams the
// pattern in over valid/ready, flushes stale signal history, then counts matches.
module pattern_decoder_ctrl #(
    parameter int N     = 1024,
    parameter int CNT_W = 16,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start_prgm,
    input  logic             prgm_bit,
    input  logic             prgm_valid,
    output logic             prgm_ready,
    input  logic             arm,
    input  logic             disarm,
    output logic             dec_clr,
    output logic             dec_enable,
    output logic             dec_prgm,
    input  logic             dec_out,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        PROGRAM = 3'd2,
        READY   = 3'd3,
        FILL    = 3'd4,
        DETECT  = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] LAST = LEN_W'(N - 1);

    state_t           cur;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] fill_cnt;
    logic             transfer;

    assign prgm_ready = (cur == PROGRAM);
    assign transfer   = prgm_valid & prgm_ready;
    assign dec_enable = transfer;
    assign dec_prgm   = transfer & prgm_bit;
    // clr reaches the decoder in the same cycle so an abort never leaves a partial pattern
    assign dec_clr    = clr | (cur == CLEAR);
    assign state      = cur;

    always_ff @(posedge clk) begin
        if (clr) begin
            cur         <= IDLE;
            bit_cnt     <= '0;
            fill_cnt    <= '0;
            match_count <= '0;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            case (cur)
                IDLE: if (start_prgm) cur <= CLEAR;
                CLEAR: begin
                    cur     <= PROGRAM;
                    bit_cnt <= '0;
                end
                PROGRAM: if (transfer) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST) cur <= READY;
                end
                READY: begin
                    if (start_prgm) begin
                        cur <= CLEAR;
                    end else if (arm) begin
                        cur         <= FILL;
                        fill_cnt    <= '0;
                        match_count <= '0;
                    end
                end
                FILL, DETECT: begin
                    // FILL ignores dec_out until the signal register holds only post-arm bits
                    if (cur == FILL) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == LAST) cur <= DETECT;
                    end else if (dec_out) begin
                        match_pulse <= 1'b1;
                        if (match_count != '1) match_count <= match_count + 1'b1;
                    end
                    if (start_prgm)  cur <= CLEAR;
                    else if (disarm) cur <= READY;
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_decoder_ctrl.sv
// Bench for pattern_decoder_ctrl with N=8: a behavioural decoder closes the loop
// and a sliding-window history predicts every match pulse and count.
module tb_pattern_decoder_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             clr;
    logic             start_prgm;
    logic             prgm_bit;
    logic             prgm_valid;
    logic             prgm_ready;
    logic             arm;
    logic             disarm;
    logic             dec_clr;
    logic             dec_enable;
    logic             dec_prgm;
    logic             dec_out;
    logic             match_pulse;
    logic [CNT_W-1:0] match_count;
    logic [2:0]       state;

    logic             sig_bit;
    logic [N-1:0]     prog_reg;
    logic [N-1:0]     sig_reg;

    int checks = 0;
    int errors = 0;
    int exp_cnt;
    bit hist[$];

    pattern_decoder_ctrl #(.N(N), .CNT_W(CNT_W), .LEN_W(4)) dut (
        .clk(clk), .clr(clr), .start_prgm(start_prgm), .prgm_bit(prgm_bit),
        .prgm_valid(prgm_valid), .prgm_ready(prgm_ready), .arm(arm), .disarm(disarm),
        .dec_clr(dec_clr), .dec_enable(dec_enable), .dec_prgm(dec_prgm), .dec_out(dec_out),
        .match_pulse(match_pulse), .match_count(match_count), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural decoder: program SIPO, signal SIPO (shifts every cycle), comparator
    always @(posedge clk) begin
        if (dec_clr) begin
            prog_reg <= '0;
            sig_reg  <= '0;
        end else begin
            if (dec_enable) prog_reg <= {prog_reg[N-2:0], dec_prgm};
            sig_reg <= {sig_reg[N-2:0], sig_bit};
        end
    end
    assign dec_out = (prog_reg == sig_reg);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Last N signal bits, oldest in the MSB
    function automatic logic [N-1:0] window();
        logic [N-1:0] w;
        for (int j = 0; j < N; j++) w[j] = hist[hist.size() - 1 - j];
        return w;
    endfunction

    function automatic int sat_inc(input int c);
        return (c < SAT) ? c + 1 : SAT;
    endfunction

    task automatic do_program(input logic [N-1:0] pat);
        sig_bit = 1'b0;
        start_prgm = 1'b1; tick();
        start_prgm = 1'b0; tick();
        for (int i = 0; i < N; i++) begin
            prgm_valid = 1'b1; prgm_bit = pat[N-1-i]; tick();
        end
        prgm_valid = 1'b0; prgm_bit = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1; tick(); arm = 1'b0;
        hist = {};
        for (int i = 0; i < N; i++) hist.push_back(1'b0);
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int c = 0; c < 2; c++) begin
            start_prgm = 1'($urandom); prgm_bit = 1'($urandom); prgm_valid = 1'($urandom);
            arm = 1'($urandom); disarm = 1'($urandom); sig_bit = 1'($urandom);
            #1;
            checks++;
            if (dec_clr !== 1'b1) begin errors++; $display("FAIL reset_dec_clr got %b want 1", dec_clr); end
            tick();
            checks++;
            if (state !== 3'd0 || match_count !== '0 || match_pulse !== 1'b0 || prgm_ready !== 1'b0 || dec_enable !== 1'b0) begin
                errors++;
                $display("FAIL reset_state got st=%0d cnt=%0d pulse=%b rdy=%b en=%b want 0 0 0 0 0",
                         state, match_count, match_pulse, prgm_ready, dec_enable);
            end
        end
        clr = 1'b0; start_prgm = 1'b0; prgm_valid = 1'b0; prgm_bit = 1'b0;
        arm = 1'b0; disarm = 1'b0; sig_bit = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || dec_clr !== 1'b0) begin
            errors++; $display("FAIL idle_hold got st=%0d clr=%b want 0 0", state, dec_clr);
        end
    endtask

    task automatic test_program_stalls();
        logic [N-1:0] pat = 8'b1011_0010;
        int sent = 0;
        int clr_cycles = 0;
        start_prgm = 1'b1; #1;
        if (dec_clr) clr_cycles++;
        tick(); start_prgm = 1'b0; #1;
        if (dec_clr) clr_cycles++;
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL clear_state got %0d want 1", state); end
        tick();
        for (int k = 0; k < 2 * N; k++) begin
            prgm_valid = 1'(k % 2);
            prgm_bit   = prgm_valid ? pat[N-1-sent] : 1'($urandom);
            start_prgm = 1'($urandom);
            #1;
            if (dec_clr) clr_cycles++;
            checks++;
            if (dec_enable !== prgm_valid || prgm_ready !== 1'b1) begin
                errors++; $display("FAIL prog_enable k=%0d got en=%b rdy=%b want en=%b rdy=1", k, dec_enable, prgm_ready, prgm_valid);
            end
            if (prgm_valid) begin
                checks++;
                if (dec_prgm !== pat[N-1-sent]) begin
                    errors++; $display("FAIL prog_bit idx=%0d got %b want %b", sent, dec_prgm, pat[N-1-sent]);
                end
                sent++;
            end
            tick();
        end
        prgm_valid = 1'b0; start_prgm = 1'b0; #1;
        checks++;
        if (clr_cycles != 1) begin errors++; $display("FAIL clear_cycles got %0d want 1", clr_cycles); end
        checks++;
        if (state !== 3'd3 || prgm_ready !== 1'b0 || prog_reg !== pat) begin
            errors++; $display("FAIL prog_done got st=%0d rdy=%b reg=%b want 3 0 %b", state, prgm_ready, prog_reg, pat);
        end
    endtask

    task automatic test_fill_mask();
        do_program('0);
        do_arm();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (state !== 3'd4 || match_pulse !== 1'b0) begin
                errors++; $display("FAIL fill_mask i=%0d got st=%0d pulse=%b want 4 0", i, state, match_pulse);
            end
            tick();
        end
        checks++;
        if (state !== 3'd5 || match_pulse !== 1'b0) begin
            errors++; $display("FAIL detect_first got st=%0d pulse=%b want 5 0", state, match_pulse);
        end
        tick();
        tick();
        checks++;
        if (match_pulse !== 1'b1 || match_count !== 4'd2) begin
            errors++; $display("FAIL detect_cont got pulse=%b cnt=%0d want 1 2", match_pulse, match_count);
        end
        disarm = 1'b1; tick(); disarm = 1'b0;
        checks++;
        if (state !== 3'd3 || match_pulse !== 1'b1 || match_count !== 4'd3) begin
            errors++; $display("FAIL disarm got st=%0d pulse=%b cnt=%0d want 3 1 3", state, match_pulse, match_count);
        end
        arm = 1'b0; tick();
        checks++;
        if (match_pulse !== 1'b0 || match_count !== 4'd3) begin
            errors++; $display("FAIL ready_hold got pulse=%b cnt=%0d want 0 3", match_pulse, match_count);
        end
    endtask

    task automatic run_stream(input logic [N-1:0] pat, input bit bits[$], input bit in_fill);
        logic m;
        foreach (bits[i]) begin
            sig_bit = bits[i];
            m = !in_fill && (window() == pat);
            tick();
            hist.push_back(bits[i]);
            if (m) exp_cnt = sat_inc(exp_cnt);
            checks++;
            if (match_pulse !== m || match_count !== CNT_W'(exp_cnt)) begin
                errors++; $display("FAIL stream i=%0d got pulse=%b cnt=%0d want %b %0d", i, match_pulse, match_count, m, exp_cnt);
            end
        end
        sig_bit = 1'b0;
    endtask

    task automatic test_detect();
        logic [N-1:0] pat = 8'b1011_0010;
        bit s[$];
        do_program(pat);
        do_arm();
        checks++;
        if (match_count !== '0) begin errors++; $display("FAIL arm_clears got %0d want 0", match_count); end
        s = {}; for (int i = 0; i < N; i++) s.push_back(1'b0);
        run_stream(pat, s, 1'b1);
        s = {1'b0, 1'b0, 1'b0};
        for (int i = 0; i < N; i++) s.push_back(pat[N-1-i]);
        s.push_back(1'b0); s.push_back(1'b0);
        run_stream(pat, s, 1'b0);
        checks++;
        if (match_count !== 4'd1) begin errors++; $display("FAIL detect_one got %0d want 1", match_count); end
        s = {};
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) s.push_back(pat[N-1-i]);
        s.push_back(1'b0); s.push_back(1'b0);
        run_stream(pat, s, 1'b0);
        checks++;
        if (match_count !== 4'd4) begin errors++; $display("FAIL detect_b2b got %0d want 4", match_count); end
    endtask

    task automatic test_saturation();
        do_program('0);
        do_arm();
        for (int i = 0; i < N + 21; i++) tick();
        checks++;
        if (match_count !== 4'd15 || match_pulse !== 1'b1) begin
            errors++; $display("FAIL saturate got cnt=%0d pulse=%b want 15 1", match_count, match_pulse);
        end
        start_prgm = 1'b1; disarm = 1'b1; tick();
        start_prgm = 1'b0; disarm = 1'b0;
        checks++;
        if (state !== 3'd1 || match_count !== 4'd15 || match_pulse !== 1'b1) begin
            errors++; $display("FAIL priority got st=%0d cnt=%0d pulse=%b want 1 15 1", state, match_count, match_pulse);
        end
    endtask

    task automatic test_midop_reset();
        logic [N-1:0] a = 8'($urandom);
        logic [N-1:0] b = 8'($urandom);
        tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL to_program got %0d want 2", state); end
        for (int i = 0; i < 5; i++) begin prgm_valid = 1'b1; prgm_bit = a[N-1-i]; tick(); end
        clr = 1'b1; tick(); clr = 1'b0; prgm_valid = 1'b0;
        checks++;
        if (state !== 3'd0 || match_count !== '0 || prgm_ready !== 1'b0) begin
            errors++; $display("FAIL midop_clr got st=%0d cnt=%0d rdy=%b want 0 0 0", state, match_count, prgm_ready);
        end
        start_prgm = 1'b1; tick(); start_prgm = 1'b0; tick();
        for (int i = 0; i < N - 1; i++) begin prgm_valid = 1'b1; prgm_bit = b[N-1-i]; tick(); end
        prgm_valid = 1'b0;
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL partial_prog got %0d want 2", state); end
        prgm_valid = 1'b1; prgm_bit = b[0]; tick(); prgm_valid = 1'b0;
        checks++;
        if (state !== 3'd3 || prog_reg !== b) begin
            errors++; $display("FAIL reprog got st=%0d reg=%b want 3 %b", state, prog_reg, b);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pat;
        bit s[$];
        for (int r = 0; r < 3; r++) begin
            pat = 8'($urandom);
            do_program(pat);
            do_arm();
            s = {}; for (int i = 0; i < N; i++) s.push_back(1'($urandom));
            run_stream(pat, s, 1'b1);
            s = {};
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < int'($urandom_range(0, 5)); i++) s.push_back(1'($urandom));
                for (int i = 0; i < N; i++) s.push_back(pat[N-1-i]);
            end
            s.push_back(1'($urandom));
            run_stream(pat, s, 1'b0);
            disarm = 1'b1; tick(); disarm = 1'b0;
            checks++;
            if (state !== 3'd3 || match_count !== CNT_W'(exp_cnt)) begin
                errors++; $display("FAIL rand_disarm got st=%0d cnt=%0d want 3 %0d", state, match_count, exp_cnt);
            end
        end
    endtask

    initial begin
        clr = 1'b1; start_prgm = 1'b0; prgm_bit = 1'b0; prgm_valid = 1'b0;
        arm = 1'b0; disarm = 1'b0; sig_bit = 1'b0;
        test_reset();
        test_program_stalls();
        test_fill_mask();
        test_detect();
        test_saturation();
        test_midop_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
